// File: rtl/mastermind_game_ctrl_if.sv
// Bundles the Mastermind game controller's button/secret inputs and its board-state outputs.
// The master side drives the buttons and the slave side (the controller) drives the outputs.
interface mastermind_game_ctrl_if;
  logic        start;
  logic [11:0] secret_code;
  logic        btn_left;
  logic        btn_right;
  logic        btn_up;
  logic        btn_down;
  logic        btn_submit;
  logic [71:0] matrix_flat;
  logic [2:0]  guess_num;
  logic        q_Input;
  logic        q_Win;
  logic        q_Lose;
  logic [1:0]  cursor_col;
  logic [35:0] feedback_flat;

  modport master (
    output start, secret_code, btn_left, btn_right, btn_up, btn_down, btn_submit,
    input  matrix_flat, guess_num, q_Input, q_Win, q_Lose, cursor_col, feedback_flat
  );

  modport slave (
    input  start, secret_code, btn_left, btn_right, btn_up, btn_down, btn_submit,
    output matrix_flat, guess_num, q_Input, q_Win, q_Lose, cursor_col, feedback_flat
  );
endinterface

// File: rtl/mastermind_game_ctrl.sv
// Mastermind game sequencer: edits the current guess row from button pulses, scores it
// against the latched secret over 2+NUM_COLORS cycles, and exposes the board for rendering.
module mastermind_game_ctrl #(
  parameter int NUM_COLORS = 6,
  parameter int MAX_ROWS   = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mastermind_game_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INPUT, EXACT, PARTIAL, JUDGE, WIN, LOSE} state_t;

  localparam logic [2:0] NC       = 3'(NUM_COLORS);
  localparam logic [2:0] LAST_ROW = 3'(MAX_ROWS - 1);

  state_t     state_q, state_d;
  logic [2:0] mat_q [6][4];
  logic [2:0] mat_d [6][4];
  logic [5:0] fb_q [6];
  logic [5:0] fb_d [6];
  logic [2:0] sec_q [4];
  logic [2:0] sec_d [4];
  logic [2:0] guess_q, guess_d;
  logic [1:0] cur_q, cur_d;
  logic [2:0] exact_q, exact_d, acc_q, acc_d, col_q, col_d;
  logic [3:0] s_unm_q, s_unm_d, g_unm_q, g_unm_d;

  logic [2:0] code_f [4];
  logic [2:0] row_g [4];
  logic       secret_ok, start_ok, row_full;
  logic [2:0] exact_cnt, cnt_s, cnt_g;
  logic [3:0] s_unm, g_unm;

  function automatic logic [2:0] color_up(input logic [2:0] v);
    return (v >= NC) ? 3'd1 : v + 3'd1;
  endfunction

  function automatic logic [2:0] color_down(input logic [2:0] v);
    return (v <= 3'd1) ? NC : v - 3'd1;
  endfunction

  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

  assign code_f[0] = bus.secret_code[2:0];
  assign code_f[1] = bus.secret_code[5:3];
  assign code_f[2] = bus.secret_code[8:6];
  assign code_f[3] = bus.secret_code[11:9];
  assign row_g     = mat_q[guess_q];
  assign start_ok  = bus.start && secret_ok;

  always_comb begin
    secret_ok = 1'b1;
    row_full  = 1'b1;
    exact_cnt = '0;
    s_unm     = '0;
    g_unm     = '0;
    cnt_s     = '0;
    cnt_g     = '0;
    for (int c = 0; c < 4; c++) begin
      if (code_f[c[1:0]] == 3'd0 || code_f[c[1:0]] > NC) secret_ok = 1'b0;
      if (row_g[c[1:0]] == 3'd0) row_full = 1'b0;
      if (sec_q[c[1:0]] == row_g[c[1:0]]) begin
        exact_cnt = exact_cnt + 3'd1;
      end else begin
        s_unm[c[1:0]] = 1'b1;
        g_unm[c[1:0]] = 1'b1;
      end
      // Per-colour tallies only look at slots left over after exact matches.
      if (s_unm_q[c[1:0]] && sec_q[c[1:0]] == col_q) cnt_s = cnt_s + 3'd1;
      if (g_unm_q[c[1:0]] && row_g[c[1:0]] == col_q) cnt_g = cnt_g + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mat_q   <= '{default: '0};
      fb_q    <= '{default: '0};
      sec_q   <= '{default: '0};
      guess_q <= '0;
      cur_q   <= '0;
      exact_q <= '0;
      acc_q   <= '0;
      col_q   <= '0;
      s_unm_q <= '0;
      g_unm_q <= '0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      fb_q    <= fb_d;
      sec_q   <= sec_d;
      guess_q <= guess_d;
      cur_q   <= cur_d;
      exact_q <= exact_d;
      acc_q   <= acc_d;
      col_q   <= col_d;
      s_unm_q <= s_unm_d;
      g_unm_q <= g_unm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, WIN, LOSE: if (start_ok) state_d = INPUT;
      INPUT:           if (bus.btn_submit && row_full) state_d = EXACT;
      EXACT:           state_d = PARTIAL;
      PARTIAL:         if (col_q == NC) state_d = JUDGE;
      JUDGE: begin
        if (exact_q == 3'd4)          state_d = WIN;
        else if (guess_q == LAST_ROW) state_d = LOSE;
        else                          state_d = INPUT;
      end
      default:         state_d = IDLE;
    endcase
  end

  always_comb begin
    sec_d   = sec_q;
    mat_d   = mat_q;
    fb_d    = fb_q;
    guess_d = guess_q;
    cur_d   = cur_q;
    exact_d = exact_q;
    acc_d   = acc_q;
    col_d   = col_q;
    s_unm_d = s_unm_q;
    g_unm_d = g_unm_q;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start_ok) begin
          sec_d   = code_f;
          mat_d   = '{default: '0};
          fb_d    = '{default: '0};
          guess_d = '0;
          cur_d   = '0;
        end
      end
      INPUT: begin
        // A submit pulse consumes the cycle even when the row is incomplete.
        if (!bus.btn_submit) begin
          if (bus.btn_up)          mat_d[guess_q][cur_q] = color_up(row_g[cur_q]);
          else if (bus.btn_down)   mat_d[guess_q][cur_q] = color_down(row_g[cur_q]);
          else if (bus.btn_left)   cur_d = cur_q - 2'd1;
          else if (bus.btn_right)  cur_d = cur_q + 2'd1;
        end
      end
      EXACT: begin
        exact_d = exact_cnt;
        s_unm_d = s_unm;
        g_unm_d = g_unm;
        acc_d   = '0;
        col_d   = 3'd1;
      end
      PARTIAL: begin
        acc_d = acc_q + min3(cnt_s, cnt_g);
        col_d = col_q + 3'd1;
      end
      JUDGE: begin
        fb_d[guess_q] = {exact_q, acc_q};
        if (exact_q != 3'd4 && guess_q != LAST_ROW) begin
          guess_d = guess_q + 3'd1;
          cur_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.q_Input    = (state_q == INPUT);
    bus.q_Win      = (state_q == WIN);
    bus.q_Lose     = (state_q == LOSE);
    bus.guess_num  = guess_q;
    bus.cursor_col = cur_q;
  end

  for (genvar r = 0; r < 6; r++) begin : g_row
    assign bus.feedback_flat[r*6 +: 6] = fb_q[r];
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign bus.matrix_flat[r*12 + c*3 +: 3] = mat_q[r][c];
    end
  end
endmodule
